// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, width constant and special-case result helper for seq_divider
package div_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} div_state_t;

  typedef struct packed {
    logic                    hit;
    logic                    dz;
    logic [XLEN_DEFAULT-1:0] value;
  } special_t;

  // Operands arrive zero-extended; width selects the active XLEN so 32-bit builds share this helper.
  function automatic special_t special_result(input logic is_signed, input logic want_rem,
                                              input logic [XLEN_DEFAULT-1:0] a,
                                              input logic [XLEN_DEFAULT-1:0] b,
                                              input int width);
    logic [XLEN_DEFAULT-1:0] mask;
    logic [XLEN_DEFAULT-1:0] min_int;
    logic                    ovf;
    special_t                s;
    mask    = (width >= XLEN_DEFAULT) ? '1 : ((XLEN_DEFAULT'(1) << width) - XLEN_DEFAULT'(1));
    min_int = XLEN_DEFAULT'(1) << (width - 1);
    ovf     = is_signed && ((a & mask) == min_int) && ((b & mask) == mask);
    s.dz    = ((b & mask) == '0);
    s.hit   = s.dz || ovf;
    if (s.dz)
      s.value = want_rem ? a : mask;
    else if (ovf)
      s.value = want_rem ? '0 : min_int;
    else
      s.value = '0;
    return s;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/valid handshake bundle between EX stage and seq_divider
interface seq_divider_if #(parameter int XLEN = div_pkg::XLEN_DEFAULT);
  logic            start;
  logic            is_signed;
  logic            want_rem;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;
  logic            div_zero;

  modport master (output start, is_signed, want_rem, a, b,
                  input  busy, valid, result, div_zero);
  modport slave  (input  start, is_signed, want_rem, a, b,
                  output busy, valid, result, div_zero);
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step #(parameter int XLEN = div_pkg::XLEN_DEFAULT) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  // rem < divisor, so the XLEN+1-bit difference is negative exactly when its top bit is set.
  assign rem_sh = {rem, quo[XLEN-1]};
  assign trial  = rem_sh - {1'b0, divisor};

  always_comb begin
    rem_next = rem_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative RV64M DIV/DIVU/REM/REMU, one quotient bit per cycle
// Optional SEQ_DIVIDER_FAST_EXC_EN: divide-by-zero and signed overflow skip ITER.
module seq_divider #(parameter int XLEN = div_pkg::XLEN_DEFAULT) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave dif
);
  import div_pkg::*;

  localparam int CW = $clog2(XLEN);

  div_state_t      state_q, state_d;
  logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, dvsr_q, result_q;
  logic [XLEN-1:0] rem_n, quo_n, a_mag, b_mag;
  logic [CW-1:0]   count_q;
  logic            sgn_q, rsel_q, q_neg_q, r_neg_q, valid_q, div_zero_q;
  special_t        sp;

  assign a_mag = (sgn_q && a_q[XLEN-1]) ? -a_q : a_q;
  assign b_mag = (sgn_q && b_q[XLEN-1]) ? -b_q : b_q;
  assign sp    = special_result(sgn_q, rsel_q, XLEN_DEFAULT'(a_q), XLEN_DEFAULT'(b_q), XLEN);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dif.start) state_d = PREP;
`ifdef SEQ_DIVIDER_FAST_EXC_EN
      PREP: state_d = sp.hit ? DONE : ITER;
`else
      PREP: state_d = ITER;
`endif
      ITER: if (count_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0; b_q <= '0; rem_q <= '0; quo_q <= '0; dvsr_q <= '0; result_q <= '0;
      count_q <= '0; sgn_q <= 1'b0; rsel_q <= 1'b0; q_neg_q <= 1'b0; r_neg_q <= 1'b0;
      valid_q <= 1'b0; div_zero_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (dif.start) begin
          a_q    <= dif.a;
          b_q    <= dif.b;
          sgn_q  <= dif.is_signed;
          rsel_q <= dif.want_rem;
        end
        PREP: begin
          rem_q   <= '0;
          quo_q   <= a_mag;
          dvsr_q  <= b_mag;
          count_q <= CW'(XLEN - 1);
          q_neg_q <= sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          r_neg_q <= sgn_q & a_q[XLEN-1];
        end
        ITER: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          if (count_q != '0) count_q <= count_q - 1'b1;
        end
        DONE: begin
          valid_q    <= 1'b1;
          div_zero_q <= sp.dz;
          if (sp.hit)      result_q <= sp.value[XLEN-1:0];
          else if (rsel_q) result_q <= r_neg_q ? -rem_q : rem_q;
          else             result_q <= q_neg_q ? -quo_q : quo_q;
        end
        default: ;
      endcase
    end
  end

  assign dif.busy     = (state_q != IDLE);
  assign dif.valid    = valid_q;
  assign dif.result   = result_q;
  assign dif.div_zero = div_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference model
module tb_seq_divider #(parameter int XLEN = 64);

`ifdef SEQ_DIVIDER_FAST_EXC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  seq_divider_if #(.XLEN(XLEN)) dif();
  seq_divider #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .dif(dif.slave));

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] rnd();
    return XLEN'({$urandom(), $urandom()});
  endfunction

  function automatic int lat_for(input bit special);
    return (FAST && special) ? 2 : XLEN + 2;
  endfunction

  // RISC-V M semantics straight from the arithmetic definition.
  function automatic void ref_div(input logic sgn, input logic wr, input logic [XLEN-1:0] av,
                                  input logic [XLEN-1:0] bv, output logic [XLEN-1:0] v,
                                  output logic dz, output bit special);
    logic signed [XLEN-1:0] sa, sb;
    sa = av; sb = bv; dz = 1'b0; special = 1'b1;
    if (bv == '0) begin
      dz = 1'b1; v = wr ? av : ONES;
    end else if (sgn && av == MIN_INT && bv == ONES) begin
      v = wr ? '0 : MIN_INT;
    end else begin
      special = 1'b0;
      if (sgn) v = wr ? XLEN'(sa % sb) : XLEN'(sa / sb);
      else     v = wr ? av % bv : av / bv;
    end
  endfunction

  task automatic do_op(input logic sgn, input logic wr, input logic [XLEN-1:0] av,
                       input logic [XLEN-1:0] bv, output int lat,
                       output logic [XLEN-1:0] res, output logic dz, output logic busy_err);
    dif.start = 1'b1; dif.is_signed = sgn; dif.want_rem = wr; dif.a = av; dif.b = bv;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.is_signed = ~sgn; dif.want_rem = ~wr; dif.a = rnd(); dif.b = rnd();
    lat = -1; res = '0; dz = 1'b0; busy_err = 1'b0;
    for (int n = 1; n <= XLEN + 8; n++) begin
      @(posedge clk); #1;
      if (dif.valid) begin
        lat = n; res = dif.result; dz = dif.div_zero; busy_err = busy_err | dif.busy;
        break;
      end
      if (!dif.busy) busy_err = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({dif.busy, dif.valid, dif.div_zero} !== 3'b000 || dif.result !== '0) begin
      tests_failed++;
      $display("FAIL reset_state busy/valid/dz=%b result=%h required 000/0",
               {dif.busy, dif.valid, dif.div_zero}, dif.result);
    end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic [XLEN-1:0] res; logic dz, be;
    for (int i = 0; i < 2; i++) begin
      do_op(1'b0, i[0], XLEN'(100), XLEN'(7), lat, res, dz, be);
      tests_run++;
      if (res !== (i == 0 ? XLEN'(14) : XLEN'(2)) || dz !== 1'b0 || lat != XLEN + 2 || be) begin
        tests_failed++;
        $display("FAIL unsigned_100_7 wr=%0d result=%0d dz=%b lat=%0d busy_err=%b required %0d/0/%0d/0",
                 i, res, dz, lat, be, (i == 0 ? 14 : 2), XLEN + 2);
      end
    end
  endtask

  task automatic test_signed();
    logic [XLEN-1:0] ta[4], tbv[4], te[4];
    int lat; logic [XLEN-1:0] res; logic dz, be;
    ta[0] = -XLEN'(7); tbv[0] = XLEN'(2);  te[0] = -XLEN'(3);
    ta[1] = -XLEN'(7); tbv[1] = XLEN'(2);  te[1] = -XLEN'(1);
    ta[2] = XLEN'(7);  tbv[2] = -XLEN'(2); te[2] = -XLEN'(3);
    ta[3] = XLEN'(7);  tbv[3] = -XLEN'(2); te[3] = XLEN'(1);
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, i[0], ta[i], tbv[i], lat, res, dz, be);
      tests_run++;
      if (res !== te[i] || dz !== 1'b0 || lat != XLEN + 2) begin
        tests_failed++;
        $display("FAIL signed_%0d result=%h dz=%b lat=%0d required %h/0/%0d", i, res, dz, lat, te[i], XLEN + 2);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [XLEN-1:0] res; logic dz, be;
    for (int i = 0; i < 4; i++) begin
      do_op(i[1], i[0], XLEN'(5), '0, lat, res, dz, be);
      tests_run++;
      if (res !== (i[0] ? XLEN'(5) : ONES) || dz !== 1'b1 || lat != lat_for(1'b1)) begin
        tests_failed++;
        $display("FAIL div_zero_%0d result=%h dz=%b lat=%0d required %h/1/%0d",
                 i, res, dz, lat, (i[0] ? XLEN'(5) : ONES), lat_for(1'b1));
      end
    end
  endtask

  task automatic test_overflow();
    int lat; logic [XLEN-1:0] res; logic dz, be;
    for (int i = 0; i < 2; i++) begin
      do_op(1'b1, i[0], MIN_INT, ONES, lat, res, dz, be);
      tests_run++;
      if (res !== (i[0] ? '0 : MIN_INT) || dz !== 1'b0 || lat != lat_for(1'b1)) begin
        tests_failed++;
        $display("FAIL overflow_wr%0d result=%h dz=%b lat=%0d required %h/0/%0d",
                 i, res, dz, lat, (i[0] ? '0 : MIN_INT), lat_for(1'b1));
      end
    end
  endtask

  task automatic test_ignored_start();
    int pulses = 0, first = -1;
    logic [XLEN-1:0] res = '0;
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.want_rem = 1'b0; dif.a = XLEN'(100); dif.b = XLEN'(7);
    @(posedge clk); #1;
    for (int n = 1; n <= XLEN + 12; n++) begin
      if (n == 10 || n == (XLEN * 5) / 8) begin
        dif.start = 1'b1; dif.a = rnd(); dif.b = rnd(); dif.want_rem = 1'b1;
      end else dif.start = 1'b0;
      @(posedge clk); #1;
      if (dif.valid) begin
        pulses++;
        if (first < 0) begin first = n; res = dif.result; end
      end
    end
    dif.start = 1'b0;
    tests_run++;
    if (pulses != 1 || first != XLEN + 2 || res !== XLEN'(14)) begin
      tests_failed++;
      $display("FAIL ignored_start pulses=%0d at=%0d result=%0d required 1/%0d/14", pulses, first, res, XLEN + 2);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [XLEN-1:0] res, av, bv, ev; logic dz, be, edz; bit sp;
    do_op(1'b0, 1'b1, XLEN'(100), XLEN'(7), lat, res, dz, be);
    av = rnd(); bv = rnd() >> 3;
    ref_div(1'b1, 1'b0, av, bv, ev, edz, sp);
    do_op(1'b1, 1'b0, av, bv, lat, res, dz, be);
    tests_run++;
    if (res !== ev || dz !== edz || lat != lat_for(sp) || be) begin
      tests_failed++;
      $display("FAIL back_to_back result=%h dz=%b lat=%0d busy_err=%b required %h/%b/%0d/0",
               res, dz, lat, be, ev, edz, lat_for(sp));
    end
    @(posedge clk); #1;
    tests_run++;
    if (dif.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_width valid=%b required 0", dif.valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses = 0; logic [XLEN-1:0] res; logic dz, be;
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.want_rem = 1'b0; dif.a = XLEN'(100); dif.b = XLEN'(7);
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if ({dif.busy, dif.valid} !== 2'b00 || dif.result !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid busy/valid=%b result=%h required 00/0", {dif.busy, dif.valid}, dif.result);
    end
    for (int n = 0; n < XLEN + 10; n++) begin
      @(posedge clk); #1;
      if (dif.valid) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_valid pulses=%0d required 0", pulses);
    end
    do_op(1'b0, 1'b0, XLEN'(100), XLEN'(7), lat, res, dz, be);
    tests_run++;
    if (res !== XLEN'(14) || lat != XLEN + 2) begin
      tests_failed++;
      $display("FAIL reset_mid_recover result=%0d lat=%0d required 14/%0d", res, lat, XLEN + 2);
    end
  endtask

  task automatic test_random();
    int lat; logic [XLEN-1:0] res, av, bv, ev; logic dz, be, edz, sgn, wr; bit sp;
    for (int i = 0; i < 40; i++) begin
      sgn = $urandom_range(0, 1); wr = $urandom_range(0, 1);
      av = rnd() >> $urandom_range(0, XLEN - 1);
      if ($urandom_range(0, 1)) av = -av;
      case ($urandom_range(0, 7))
        0: bv = '0;
        1: bv = ONES;
        2: bv = XLEN'($urandom_range(1, 15));
        3: begin av = MIN_INT; bv = ONES; end
        default: bv = rnd() >> $urandom_range(0, XLEN - 1);
      endcase
      ref_div(sgn, wr, av, bv, ev, edz, sp);
      do_op(sgn, wr, av, bv, lat, res, dz, be);
      tests_run++;
      if (res !== ev || dz !== edz || lat != lat_for(sp) || be) begin
        tests_failed++;
        $display("FAIL random_%0d s=%b r=%b a=%h b=%h result=%h dz=%b lat=%0d busy_err=%b required %h/%b/%0d/0",
                 i, sgn, wr, av, bv, res, dz, lat, be, ev, edz, lat_for(sp));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    dif.start = 1'b0; dif.is_signed = 1'b0; dif.want_rem = 1'b0; dif.a = '0; dif.b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative 64-bit integer divider for the RV64M execute stage; sits beside the ALU adder on the EX path.
- Computes DIV/DIVU/REM/REMU by restoring shift-subtract, one quotient bit per cycle.
- Uses a start/busy/valid handshake; the pipeline stalls EX while busy is high.

Parameters:
- XLEN, 64, operand/result width; the bench must support 32 and 64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU
- want_rem  input  1  1 = result is remainder, 0 = result is quotient
- a  input  XLEN  dividend
- b  input  XLEN  divisor
- busy  output  1  high from the cycle after acceptance until valid
- valid  output  1  one-cycle pulse; result is valid
- result  output  XLEN  quotient or remainder; held until next acceptance
- div_zero  output  1  qualified by valid; divisor was zero

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE, busy=0, valid=0, result=0, div_zero=0, internal registers=0.
- Reset mid-operation aborts immediately; no valid pulse is produced.
- States: IDLE -> PREP -> ITER -> DONE -> IDLE.
- IDLE: start=1 latches a, b, is_signed, want_rem; go to PREP. busy=1 from the next cycle.
- PREP (1 cycle):
  - Take magnitudes when is_signed=1.
  - Record q_neg = sign(a) XOR sign(b) and r_neg = sign(a).
  - Load remainder=0, quotient=|a|, count=XLEN-1.
- ITER (XLEN cycles), each cycle:
  - {rem,quo} shifted left 1.
  - trial = rem - |b|, computed XLEN+1 bits wide.
  - If trial is non-negative: rem=trial and quo LSB=1; else quo LSB=0.
  - Leave ITER when count==0; otherwise count decrements.
- DONE (1 cycle):
  - Apply signs: quotient negated if q_neg; remainder negated if r_neg.
  - Select result by want_rem; valid=1; busy=0 in the same cycle; next state IDLE.
- Latency: valid asserts exactly XLEN+2 cycles after the accepting edge (66 for XLEN=64). A new start is accepted in the IDLE cycle after DONE.
- start while busy=1 is ignored; no queuing.
- Inputs are sampled only at acceptance; later changes have no effect.
- Divide by zero:
  - Quotient is all ones (-1), remainder = a unmodified, div_zero=1.
  - The natural datapath result is overridden for the signed case.
- Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a, remainder = 0, div_zero=0.
- All arithmetic is performed modulo 2^XLEN except the XLEN+1-bit trial subtract.

Optional Feature:
- Macro: SEQ_DIVIDER_FAST_EXC_EN.
- Defined:
  - In PREP, divide-by-zero or signed overflow jumps directly to DONE with the special result.
  - Latency is 2 cycles after acceptance for those cases; normal cases are unchanged.
- Undefined: every operation takes XLEN+2 cycles. Special results are applied in DONE and are bit-identical to the defined case.

Decomposition:
- Package div_pkg holds:
  - Constant XLEN_DEFAULT=64.
  - typedef enum logic [1:0] div_state_t {IDLE, PREP, ITER, DONE}.
  - A function computing the special-case results.
- Sub-module div_step (combinational, one restoring iteration):
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - ITER instantiates it once.

Test Plan:
- Unsigned: a=100, b=7, is_signed=0, want_rem=0 -> result=14 after 66 cycles; repeat with want_rem=1 -> result=2.
- Signed: a=-7, b=2 -> quotient=-3, remainder=-1. Also a=7, b=-2 -> quotient=-3, remainder=1.
- Divide by zero: a=5, b=0, signed and unsigned -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5, div_zero=1. Latency is 66, or 2 with SEQ_DIVIDER_FAST_EXC_EN defined.
- Overflow: a=0x8000_0000_0000_0000, b=-1, signed -> quotient=0x8000_0000_0000_0000, remainder=0, div_zero=0.
- Handshake:
  - Pulse start again at cycles 10 and 40 of an operation -> ignored; exactly one valid pulse at 66.
  - A start in the cycle after valid is accepted.
- Reset at cycle 30 of an operation -> busy=0, valid=0, result=0 on the next edge; no valid pulse follows. A fresh 100/7 then completes normally.
